// File: rtl/pma_region_sched.sv
// pma_region_sched: CSR-programmable PMA region table with one serial range checker
// shared round-robin between NR_REQ requesters.
module pma_region_sched #(
  parameter int NR_RULES = 4,
  parameter int NR_REQ   = 2,
  parameter int REQ_ID_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [1:0]             cfg_kind_i,
  input  logic [3:0]             cfg_idx_i,
  input  logic                   cfg_en_i,
  input  logic [63:0]            cfg_base_i,
  input  logic [63:0]            cfg_len_i,
  input  logic [NR_REQ-1:0]      req_valid_i,
  input  logic [NR_REQ*64-1:0]   req_addr_i,
  output logic [NR_REQ-1:0]      req_ready_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [REQ_ID_W-1:0]    rsp_id_o,
  output logic                   rsp_nonidem_o,
  output logic                   rsp_exec_o,
  output logic                   rsp_cache_o
);
  localparam int KW = NR_RULES > 1 ? $clog2(NR_RULES) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t state, state_nx;
  logic              en_q   [3][NR_RULES];
  logic [63:0]       base_q [3][NR_RULES];
  logic [63:0]       len_q  [3][NR_RULES];
  logic [63:0]       addr;
  logic [REQ_ID_W-1:0] id, rr, gnt;
  logic [KW-1:0]     k;
  logic [2:0]        acc, hit;
  logic              any_ex, found, grant, cfg_wr;

  function automatic int wrap(input int v);
    return v >= NR_REQ ? v - NR_REQ : v;
  endfunction

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NR_REQ; i++)
      if (!found && req_valid_i[wrap(int'(rr) + i)]) begin
        found = 1'b1;
        gnt   = REQ_ID_W'(wrap(int'(rr) + i));
      end
  end

  // 65-bit limit so a region running past 2^64-1 still covers the top of memory
  always_comb begin
    hit = '0;
    for (int c = 0; c < 3; c++)
      hit[c] = en_q[c][k] && addr >= base_q[c][k] &&
               {1'b0, addr} < {1'b0, base_q[c][k]} + {1'b0, len_q[c][k]};
  end

  assign grant  = state == IDLE && !cfg_valid_i && found;
  assign cfg_wr = state == IDLE && cfg_valid_i && cfg_kind_i != 2'd3 && int'(cfg_idx_i) < NR_RULES;

  always_comb begin
    state_nx    = state;
    req_ready_o = '0;
    case (state)
      IDLE: if (grant) begin
        req_ready_o = NR_REQ'(1) << gnt;
        state_nx    = SCAN;
      end
      SCAN:    state_nx = k == KW'(NR_RULES - 1) ? RESP : SCAN;
      RESP:    state_nx = rsp_ready_i ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  assign cfg_ready_o   = state == IDLE;
  assign rsp_valid_o   = state == RESP;
  assign rsp_id_o      = id;
  assign rsp_nonidem_o = rsp_valid_o & acc[0];
  assign rsp_exec_o    = rsp_valid_o & (acc[1] | !any_ex);
  assign rsp_cache_o   = rsp_valid_o & acc[2];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      rr     <= '0;
      addr   <= '0;
      id     <= '0;
      k      <= '0;
      acc    <= '0;
      any_ex <= 1'b0;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < NR_RULES; i++) begin
          en_q[c][i]   <= 1'b0;
          base_q[c][i] <= '0;
          len_q[c][i]  <= '0;
        end
    end else begin
      state <= state_nx;
      if (cfg_wr) begin
        en_q[cfg_kind_i][cfg_idx_i[KW-1:0]]   <= cfg_en_i;
        base_q[cfg_kind_i][cfg_idx_i[KW-1:0]] <= cfg_base_i;
        len_q[cfg_kind_i][cfg_idx_i[KW-1:0]]  <= cfg_len_i;
      end
      if (grant) begin
        addr   <= req_addr_i[64*gnt +: 64];
        id     <= gnt;
        acc    <= '0;
        any_ex <= 1'b0;
        k      <= '0;
        rr     <= REQ_ID_W'(wrap(int'(gnt) + 1));
      end
      if (state == SCAN) begin
        acc    <= acc | hit;
        any_ex <= any_ex | en_q[1][k];
        k      <= k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pma_region_sched.sv
// tb_pma_region_sched: table-driven directed checks plus hand sequences for
// fairness, backpressure, cfg/lookup collision and mid-scan reset.
module tb_pma_region_sched;
  localparam int NR_RULES = 4;
  localparam int NR_REQ   = 2;
  localparam int REQ_ID_W = 2;

  logic              clk = 0, rst_n = 0;
  logic              cfg_valid = 0, cfg_ready, cfg_en = 0;
  logic [1:0]        cfg_kind = 0;
  logic [3:0]        cfg_idx = 0;
  logic [63:0]       cfg_base = 0, cfg_len = 0;
  logic [NR_REQ-1:0] req_valid = 0, req_ready;
  logic [NR_REQ*64-1:0] req_addr = 0;
  logic              rsp_valid, rsp_ready = 0, rsp_ni, rsp_ex, rsp_ca;
  logic [REQ_ID_W-1:0] rsp_id;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  pma_region_sched #(.NR_RULES(NR_RULES), .NR_REQ(NR_REQ), .REQ_ID_W(REQ_ID_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_kind_i(cfg_kind),
    .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en), .cfg_base_i(cfg_base), .cfg_len_i(cfg_len),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_nonidem_o(rsp_ni), .rsp_exec_o(rsp_ex), .rsp_cache_o(rsp_ca)
  );

  typedef struct {
    logic        do_cfg;
    logic [1:0]  kind;
    logic [3:0]  idx;
    logic        en;
    logic [63:0] base, len, addr;
    logic        ni, ex, ca;
  } vec_t;
  vec_t v [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] kind, input logic [3:0] idx, input logic en,
                           input logic [63:0] base, input logic [63:0] len);
    cfg_valid = 1; cfg_kind = kind; cfg_idx = idx; cfg_en = en; cfg_base = base; cfg_len = len;
    #1;
    chk("cfg_ready", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic lookup(input int r, input logic [63:0] a, input logic eni, input logic eex,
                        input logic eca, input string nm);
    int n;
    req_valid[r] = 1;
    req_addr[64*r +: 64] = a;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_grant"}, 64'(req_ready), 64'(NR_REQ'(1) << r));
    @(posedge clk); #1;
    req_valid[r] = 0;
    n = 1;
    while (!rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk({nm, "_lat"}, 64'(n), 64'(NR_RULES + 1));
    chk({nm, "_id"}, 64'(rsp_id), 64'(r));
    chk({nm, "_ni"}, 64'(rsp_ni), 64'(eni));
    chk({nm, "_ex"}, 64'(rsp_ex), 64'(eex));
    chk({nm, "_ca"}, 64'(rsp_ca), 64'(eca));
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, "_done"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    v[0]  = '{1'b0, 2'd0, 4'd0, 1'b0, 64'h0, 64'h0, 64'h8000_0000, 1'b0, 1'b1, 1'b0};
    v[1]  = '{1'b1, 2'd2, 4'd0, 1'b1, 64'h8000_0000, 64'h4000_0000, 64'hBFFF_FFFF, 1'b0, 1'b1, 1'b1};
    v[2]  = '{1'b0, 2'd0, 4'd0, 1'b0, 64'h0, 64'h0, 64'hC000_0000, 1'b0, 1'b1, 1'b0};
    v[3]  = '{1'b1, 2'd1, 4'd2, 1'b1, 64'h1000, 64'h1000, 64'h1800, 1'b0, 1'b1, 1'b0};
    v[4]  = '{1'b0, 2'd0, 4'd0, 1'b0, 64'h0, 64'h0, 64'h3000, 1'b0, 1'b0, 1'b0};
    v[5]  = '{1'b1, 2'd1, 4'd2, 1'b0, 64'h1000, 64'h1000, 64'h3000, 1'b0, 1'b1, 1'b0};
    v[6]  = '{1'b1, 2'd0, 4'd1, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    v[7]  = '{1'b1, 2'd0, 4'd1, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    v[8]  = '{1'b1, 2'd0, 4'd3, 1'b1, 64'h100, 64'h10, 64'h10F, 1'b1, 1'b1, 1'b0};
    v[9]  = '{1'b1, 2'd3, 4'd0, 1'b1, 64'h0, 64'hFFFF_FFFF, 64'h200, 1'b0, 1'b1, 1'b0};
    v[10] = '{1'b1, 2'd2, 4'd5, 1'b1, 64'h0, 64'h1000, 64'h200, 1'b0, 1'b1, 1'b0};
    v[11] = '{1'b1, 2'd2, 4'd3, 1'b1, 64'hC000_0000, 64'h1000, 64'hC000_0FFF, 1'b0, 1'b1, 1'b1};

    do_reset();
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_attr", {61'd0, rsp_ni, rsp_ex, rsp_ca}, 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);

    for (int i = 0; i < 12; i++) begin
      if (v[i].do_cfg) cfg_write(v[i].kind, v[i].idx, v[i].en, v[i].base, v[i].len);
      lookup(0, v[i].addr, v[i].ni, v[i].ex, v[i].ca, $sformatf("vec%0d", i));
    end

    // fairness with both requesters held, plus 3 cycles of response backpressure
    do_reset();
    req_addr = {64'h20, 64'h10};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      #1;
      while (!rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
      chk("fair_id", 64'(rsp_id), 64'(i % 2));
      if (i == 0)
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          chk("hold_valid", 64'(rsp_valid), 64'd1);
          chk("hold_id", 64'(rsp_id), 64'd0);
          chk("hold_attr", {61'd0, rsp_ni, rsp_ex, rsp_ca}, 64'b010);
          chk("hold_noreq", 64'(req_ready), 64'd0);
        end
      if (i == 3) req_valid = 0;
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      if (i < 3) chk("fair_gnt", 64'(req_ready), (i % 2 == 0) ? 64'b10 : 64'b01);
    end

    // cfg write collides with a lookup: write wins, grant follows and sees the new rule
    #1;
    cfg_valid = 1; cfg_kind = 2; cfg_idx = 0; cfg_en = 1; cfg_base = 64'h8000_0000; cfg_len = 64'h1000;
    req_valid[0] = 1; req_addr[63:0] = 64'h8000_0010;
    #1;
    chk("col_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("col_no_grant", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    cfg_valid = 0;
    req_valid[0] = 0;
    lookup(0, 64'h8000_0010, 1'b0, 1'b1, 1'b1, "col");

    // reset during SCAN discards the lookup and clears the table
    req_valid[0] = 1; req_addr[63:0] = 64'h8000_0010;
    #1;
    chk("mid_grant", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid[0] = 0;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_cfg_ready", 64'(cfg_ready), 64'd1);
    begin
      logic seen;
      seen = 0;
      repeat (NR_RULES + 2) begin @(posedge clk); #1; seen |= rsp_valid; end
      chk("mid_no_stale", 64'(seen), 64'd0);
    end
    lookup(0, 64'h8000_0010, 1'b0, 1'b1, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pma_region_sched.md
Name: pma_region_sched

Overview:
- Runtime-programmable PMA region table with three rule classes: non-idempotent, execute and cacheable.
- A single serial range-check engine is shared between up to NR_REQ requesters (e.g. fetch, LSU, PTW) through a round-robin arbiter.
- Each accepted lookup scans one rule index per cycle across all three classes, then returns the attribute bits through a valid/ready response port.
- Sits between the MMU/PMP front ends and the memory interface, replacing static region checks with CSR-programmable ones.

Parameters:
NR_RULES, 4, rules per class; legal range 1..16
NR_REQ, 2, number of requesters; legal range 1..4
REQ_ID_W, 2, width of rsp_id_o; must satisfy 2**REQ_ID_W >= NR_REQ

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
cfg_valid_i  in  1  rule write request
cfg_ready_o  out  1  rule write accepted when high together with cfg_valid_i
cfg_kind_i  in  2  rule class: 0 non-idempotent, 1 execute, 2 cacheable, 3 reserved (write ignored but still handshaken)
cfg_idx_i  in  4  rule index; indices >= NR_RULES are ignored but still handshaken
cfg_en_i  in  1  rule enable
cfg_base_i  in  64  region base address
cfg_len_i  in  64  region length in bytes
req_valid_i  in  NR_REQ  per-requester lookup valid
req_addr_i  in  NR_REQ*64  flattened addresses; requester r uses bits [64r+63:64r]
req_ready_o  out  NR_REQ  per-requester accept, one-hot or zero
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_id_o  out  REQ_ID_W  index of the requester being answered
rsp_nonidem_o  out  1  address lies in a non-idempotent region
rsp_exec_o  out  1  address lies in an execute region
rsp_cache_o  out  1  address lies in a cacheable region

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is synchronous and active-low.
- Reset values:
  - state = IDLE; round-robin pointer = 0.
  - All rule enables, bases and lengths = 0.
  - All outputs = 0, except cfg_ready_o = 1.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - cfg_ready_o = 1.
  - If cfg_valid_i is high, the write commits at the clock edge and takes priority over lookups: req_ready_o = 0 that cycle.
  - Otherwise, grant the first requester with req_valid_i high, searching upward (with wrap) from the round-robin pointer.
  - On grant: req_ready_o[g] = 1. Latch the address and g; clear the accumulators; k = 0; go to SCAN.
  - Round-robin pointer becomes (g+1) mod NR_REQ.
- SCAN:
  - cfg_ready_o = 0; req_ready_o = 0.
  - Each cycle, evaluate rule k of all three classes in parallel.
  - Rule k matches when en && addr >= base && {1'b0,addr} < 65'(base)+65'(len). The 65-bit sum means base+len overflow still matches up to 2^64-1. len = 0 never matches.
  - OR each match into its class accumulator; also track whether any execute rule is enabled.
  - k increments each cycle; after k = NR_RULES-1, go to RESP.
- RESP:
  - rsp_valid_o = 1, with all rsp_* outputs held stable until rsp_ready_i is high.
  - rsp_exec_o = exec accumulator OR (no execute rule enabled); the empty execute table permits everything.
  - On rsp_valid_o && rsp_ready_i, go to IDLE the next cycle. No new grant in the same cycle.
- Latency and throughput:
  - Grant at cycle T; SCAN occupies T+1..T+NR_RULES; rsp_valid_o rises at T+NR_RULES+1.
  - Minimum period is NR_RULES+2 cycles per lookup.
- Requester rules:
  - A requester must hold req_valid_i and its address stable until it sees ready.
  - Dropping req_valid_i before grant is allowed; no lookup is recorded.
- Configuration timing:
  - Writes are possible only in IDLE, so the table is never modified mid-scan.
  - A write in the cycle after RESP completes is visible to the next grant.
- Reset mid-operation: any state returns to IDLE, the pending response is discarded, and the table is cleared.

Test Plan:
- Reset, then a lookup with the table empty: req0 addr 0x8000_0000, NR_RULES=4 → rsp_valid_o at grant+5, id=0, nonidem=0, exec=1, cache=0.
- Program cacheable rule 0, base 0x8000_0000, len 0x4000_0000 → lookup 0xBFFF_FFFF gives cache=1; lookup 0xC000_0000 gives cache=0.
- Program execute rule 2, base 0x1000, len 0x1000 → lookup 0x1800 gives exec=1; lookup 0x3000 gives exec=0. Then disable the rule and re-check 0x3000 → exec=1.
- Overflow boundary: non-idempotent rule base 0xFFFF_FFFF_FFFF_F000, len 0x2000 → lookup 0xFFFF_FFFF_FFFF_FFFF gives nonidem=1. A rule with len 0 at the same base and address never matches.
- Fairness: req0 and req1 held valid continuously → grants alternate 0,1,0,1. Holding rsp_ready_i low for 3 cycles keeps rsp_* stable and blocks further grants.
- Collision and reset:
  - cfg_valid_i with req0 valid in IDLE → write accepted, req_ready_o=0 that cycle, grant on the next cycle using the new rule.
  - rst_ni low during SCAN → next cycle state IDLE, rsp_valid_o=0, table cleared.
